// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler: register offsets, CTRL/STATUS bit
// positions, FSM encoding and the byte-strobe mask helper.
package counter_sched_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_RELOAD   = 8'h04;
  localparam logic [7:0] OFF_COMPARE  = 8'h08;
  localparam logic [7:0] OFF_COUNT    = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;
  localparam logic [7:0] OFF_PRESCALE = 8'h14;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_ONESHOT  = 1;
  localparam int CTRL_IE_MATCH = 2;
  localparam int CTRL_IE_WRAP  = 3;

  localparam int ST_MATCH = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_WRAP  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{sel[i]}};
    return m;
  endfunction

endpackage

// File: rtl/counter_sched_wb_if.sv
// Wishbone slave front end: address decode, single-cycle ack, byte-strobe merge
// against the current register value, and registered read data.
// COUNTER_SCHED_PRESCALER_EN adds the PRESCALE register decode.
module counter_sched_wb_if
  import counter_sched_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [31:0] ctrl_rd,
  input  logic [31:0] reload_rd,
  input  logic [31:0] compare_rd,
  input  logic [31:0] count_rd,
  input  logic [31:0] status_rd,
`ifdef COUNTER_SCHED_PRESCALER_EN
  input  logic [31:0] prescale_rd,
  output logic        wr_prescale,
`endif
  output logic        wr_ctrl,
  output logic        wr_reload,
  output logic        wr_compare,
  output logic        wr_count,
  output logic        wr_status,
  output logic [31:0] wr_data,
  output logic [2:0]  w1c_mask
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  off;
  logic        req, wr;
  logic [31:0] cur, mask;

  assign off  = wbs_adr_i[7:0];
  // Blocking on ack_q guarantees at least one idle cycle between acks.
  assign req  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]) & ~ack_q;
  assign wr   = req & wbs_we_i;
  assign mask = byte_mask(wbs_sel_i);

  always_comb begin
    cur = '0;
    case (off)
      OFF_CTRL:     cur = ctrl_rd;
      OFF_RELOAD:   cur = reload_rd;
      OFF_COMPARE:  cur = compare_rd;
      OFF_COUNT:    cur = count_rd;
      OFF_STATUS:   cur = status_rd;
`ifdef COUNTER_SCHED_PRESCALER_EN
      OFF_PRESCALE: cur = prescale_rd;
`endif
      default:      cur = '0;
    endcase
  end

  // Unstrobed bytes keep the register's present contents.
  assign wr_data    = (cur & ~mask) | (wbs_dat_i & mask);
  // STATUS is write-1-to-clear, so it takes the raw strobed ones, not a merge.
  assign w1c_mask   = wbs_dat_i[2:0] & mask[2:0];
  assign wr_ctrl    = wr & (off == OFF_CTRL);
  assign wr_reload  = wr & (off == OFF_RELOAD);
  assign wr_compare = wr & (off == OFF_COMPARE);
  assign wr_count   = wr & (off == OFF_COUNT);
  assign wr_status  = wr & (off == OFF_STATUS);
`ifdef COUNTER_SCHED_PRESCALER_EN
  assign wr_prescale = wr & (off == OFF_PRESCALE);
`endif

  always_comb begin
    ack_d = req;
    dat_d = req ? cur : dat_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: rtl/counter_sched_ctrl.sv
// Counter scheduler: config registers, IDLE/RUN/HALT sequencer and counter-load
// arbitration. COUNTER_SCHED_PRESCALER_EN enables a tick prescaler at 0x14.
module counter_sched_ctrl
  import counter_sched_pkg::*;
#(
  parameter int          BITS      = 32,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            la_load_valid,
  input  logic [BITS-1:0] la_load_data,
  output logic [BITS-1:0] cnt_value,
  output logic            cnt_running,
  output logic            irq
);

  logic [3:0]      ctrl_q, ctrl_d;
  logic [BITS-1:0] reload_q, reload_d;
  logic [BITS-1:0] compare_q, compare_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [2:0]      status_q, status_d;
  state_e          state_q, state_d;
  logic            irq_q, irq_d;
  logic            run_q, run_d;

  logic            wr_ctrl, wr_reload, wr_compare, wr_count, wr_status;
  logic [31:0]     wr_data;
  logic [2:0]      w1c_mask, st_set;
  logic            ld, tick;
  logic [BITS-1:0] ld_val;

`ifdef COUNTER_SCHED_PRESCALER_EN
  logic [BITS-1:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
  logic            wr_prescale;
  assign tick = (pre_cnt_q == prescale_q);
`else
  assign tick = 1'b1;
`endif

  counter_sched_wb_if #(.ADDR_BASE(ADDR_BASE)) u_wb_if (
    .clk        (clk),
    .reset      (reset),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .ctrl_rd    ({28'd0, ctrl_q}),
    .reload_rd  (reload_q),
    .compare_rd (compare_q),
    .count_rd   (cnt_q),
    .status_rd  ({29'd0, status_q}),
`ifdef COUNTER_SCHED_PRESCALER_EN
    .prescale_rd(prescale_q),
    .wr_prescale(wr_prescale),
`endif
    .wr_ctrl    (wr_ctrl),
    .wr_reload  (wr_reload),
    .wr_compare (wr_compare),
    .wr_count   (wr_count),
    .wr_status  (wr_status),
    .wr_data    (wr_data),
    .w1c_mask   (w1c_mask)
  );

  // A bus COUNT write outranks the LA port; either suppresses compare/increment.
  assign ld     = wr_count | la_load_valid;
  assign ld_val = wr_count ? wr_data[BITS-1:0] : la_load_data;

  always_comb begin
    ctrl_d    = ctrl_q;
    reload_d  = reload_q;
    compare_d = compare_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    st_set    = '0;
    if (wr_ctrl)    ctrl_d    = wr_data[3:0];
    if (wr_reload)  reload_d  = wr_data[BITS-1:0];
    if (wr_compare) compare_d = wr_data[BITS-1:0];

    case (state_q)
      RUN: begin
        if (wr_ctrl && !wr_data[CTRL_EN]) begin
          state_d = IDLE;
        end else if (!ld && tick) begin
          if (cnt_q == compare_q) begin
            st_set[ST_MATCH] = 1'b1;
            if (ctrl_q[CTRL_ONESHOT]) begin
              st_set[ST_DONE] = 1'b1;
              ctrl_d[CTRL_EN] = 1'b0;
              state_d         = HALT;
            end else begin
              cnt_d = reload_q;
            end
          end else begin
            cnt_d = cnt_q + BITS'(1);
            if (&cnt_q) st_set[ST_WRAP] = 1'b1;
          end
        end
      end
      default: begin
        if (wr_ctrl && wr_data[CTRL_EN]) begin
          state_d = RUN;
          cnt_d   = reload_q;
        end
      end
    endcase

    if (ld) cnt_d = ld_val;

    // Hardware set beats a simultaneous software clear.
    status_d = (status_q & ~(wr_status ? w1c_mask : 3'b000)) | st_set;
    // DONE is a compare event, so it shares the match enable.
    irq_d    = |(status_d & {ctrl_d[CTRL_IE_WRAP], ctrl_d[CTRL_IE_MATCH], ctrl_d[CTRL_IE_MATCH]});
    run_d    = (state_d == RUN);
  end

`ifdef COUNTER_SCHED_PRESCALER_EN
  always_comb begin
    prescale_d = wr_prescale ? wr_data[BITS-1:0] : prescale_q;
    pre_cnt_d  = pre_cnt_q;
    if (ld || (state_d == RUN && state_q != RUN)) pre_cnt_d = '0;
    else if (state_q == RUN)                      pre_cnt_d = tick ? '0 : pre_cnt_q + BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
    end else begin
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      reload_q  <= '0;
      compare_q <= '0;
      cnt_q     <= '0;
      status_q  <= '0;
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      reload_q  <= reload_d;
      compare_q <= compare_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      state_q   <= state_d;
      irq_q     <= irq_d;
      run_q     <= run_d;
    end
  end

  assign cnt_value   = cnt_q;
  assign cnt_running = run_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_counter_sched_ctrl.sv
// Directed bench for counter_sched_ctrl: periodic, one-shot, wrap, load arbitration,
// byte strobes, unmapped/miss decode and reset mid-run.
module tb_counter_sched_ctrl;
  import counter_sched_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        la_load_valid;
  logic [31:0] la_load_data;
  logic [31:0] cnt_value;
  logic        cnt_running;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] rdat;

  counter_sched_ctrl #(.BITS(32), .ADDR_BASE(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .la_load_valid(la_load_valid),
    .la_load_data (la_load_data),
    .cnt_value    (cnt_value),
    .cnt_running  (cnt_running),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one request at a negedge; returns at the negedge where ack is seen.
  task automatic xfer(input logic we, input logic [7:0] off, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
    int n;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = BASE | {24'd0, off}; wbs_dat_i = dat; wbs_sel_i = sel;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wbs_ack_o && n < 4);
    chk("ack_latency", 32'(n), 32'd1);
    rd = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat);
    logic [31:0] d;
    xfer(1'b1, off, dat, 4'hF, d);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    xfer(1'b0, off, 32'd0, 4'hF, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0; la_load_valid = 0; la_load_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_cnt", cnt_value, 32'd0);
    chk("rst_run", 32'(cnt_running), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    reset = 1'b0;
    rd(OFF_CTRL, rdat);    chk("rst_ctrl", rdat, 32'd0);

    // Periodic: 0,1,2,3,4,0 with MATCH irq the cycle after count 4
    wr(OFF_RELOAD, 32'd0);
    wr(OFF_COMPARE, 32'd4);
    wr(OFF_CTRL, 32'h5);
    chk("per_entry", cnt_value, 32'd0);
    chk("per_running", 32'(cnt_running), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("per_cnt", cnt_value, (i == 5) ? 32'd0 : 32'(i));
      chk("per_irq", 32'(irq), (i == 5) ? 32'd1 : 32'd0);
    end
    wr(OFF_STATUS, 32'h1);
    chk("per_w1c_irq", 32'(irq), 32'd0);
    wr(OFF_CTRL, 32'h0);
    chk("stop_running", 32'(cnt_running), 32'd0);
    @(negedge clk);
    chk("stop_hold", cnt_value, 32'd3);

    // One-shot: 10,11,12 then hold in HALT
    wr(OFF_RELOAD, 32'd10);
    wr(OFF_COMPARE, 32'd12);
    wr(OFF_CTRL, 32'h3);
    chk("os_entry", cnt_value, 32'd10);
    @(negedge clk); chk("os_11", cnt_value, 32'd11);
    @(negedge clk); chk("os_12", cnt_value, 32'd12);
    @(negedge clk); chk("os_hold", cnt_value, 32'd12);
    chk("os_running", 32'(cnt_running), 32'd0);
    @(negedge clk); chk("os_hold2", cnt_value, 32'd12);
    rd(OFF_STATUS, rdat);  chk("os_status", rdat, 32'h3);
    rd(OFF_CTRL, rdat);    chk("os_ctrl", rdat, 32'h2);
    chk("os_irq", 32'(irq), 32'd0);
    wr(OFF_STATUS, 32'h7);

    // Wrap from all-ones
    wr(OFF_COMPARE, 32'd5);
    wr(OFF_RELOAD, 32'hFFFF_FFFE);
    wr(OFF_COUNT, 32'hFFFF_FFFE);
    chk("wrap_load", cnt_value, 32'hFFFF_FFFE);
    wr(OFF_CTRL, 32'h9);
    chk("wrap_entry", cnt_value, 32'hFFFF_FFFE);
    @(negedge clk); chk("wrap_ones", cnt_value, 32'hFFFF_FFFF);
    chk("wrap_irq0", 32'(irq), 32'd0);
    @(negedge clk); chk("wrap_zero", cnt_value, 32'd0);
    chk("wrap_irq1", 32'(irq), 32'd1);
    rd(OFF_STATUS, rdat);  chk("wrap_status", rdat, 32'h4);
    wr(OFF_CTRL, 32'h0);
    wr(OFF_STATUS, 32'h7);
    chk("wrap_clr_irq", 32'(irq), 32'd0);

    // Arbitration: bus COUNT write beats LA in the same cycle
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
    wbs_adr_i = BASE | 32'h0C; wbs_dat_i = 32'h100;
    la_load_valid = 1; la_load_data = 32'h200;
    @(negedge clk);
    chk("arb_ack", 32'(wbs_ack_o), 32'd1);
    chk("arb_wb", cnt_value, 32'h100);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    @(negedge clk);
    chk("arb_la", cnt_value, 32'h200);
    la_load_valid = 0;

    // Byte strobes and unmapped offsets
    xfer(1'b1, OFF_COMPARE, 32'hAABB_CCDD, 4'b0101, rdat);
    rd(OFF_COMPARE, rdat); chk("sel_compare", rdat, 32'h00BB_00DD);
    xfer(1'b1, OFF_RELOAD, 32'h1234_5678, 4'b1000, rdat);
    rd(OFF_RELOAD, rdat);  chk("sel_reload", rdat, 32'h12FF_FFFE);
    wr(8'h40, 32'hDEAD_BEEF);
    rd(8'h40, rdat);       chk("unmap_rd", rdat, 32'd0);
    @(negedge clk);        chk("unmap_single_ack", 32'(wbs_ack_o), 32'd0);
    wr(OFF_PRESCALE, 32'd3);
    rd(OFF_PRESCALE, rdat);
`ifdef COUNTER_SCHED_PRESCALER_EN
    chk("prescale_rd", rdat, 32'd3);
    wr(OFF_PRESCALE, 32'd0);
`else
    chk("prescale_rd", rdat, 32'd0);
`endif

    // Address outside the block's window must not be acknowledged
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 32'h100;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (wbs_ack_o) n++;
    end
    chk("miss_no_ack", 32'(n), 32'd0);
    wbs_cyc_i = 0; wbs_stb_i = 0;

    // Reset during RUN with a transfer outstanding
    wr(OFF_RELOAD, 32'd0);
    wr(OFF_COMPARE, 32'd2);
    wr(OFF_CTRL, 32'h5);
    repeat (3) @(negedge clk);
    wr(OFF_COMPARE, 32'd20);
    chk("rr_irq_before", 32'(irq), 32'd1);
    n = 0;
    while (cnt_value != 32'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rr_reach7", cnt_value, 32'd7);
    reset = 1'b1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE | 32'h10;
    @(negedge clk);
    chk("rr_cnt", cnt_value, 32'd0);
    chk("rr_running", 32'(cnt_running), 32'd0);
    chk("rr_ack", 32'(wbs_ack_o), 32'd0);
    chk("rr_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    wbs_cyc_i = 0; wbs_stb_i = 0;
    rd(OFF_STATUS, rdat);  chk("rr_status", rdat, 32'd0);
    rd(OFF_CTRL, rdat);    chk("rr_ctrl", rdat, 32'd0);
    @(negedge clk);        chk("rr_idle_hold", cnt_value, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_sched_ctrl.md
Name: counter_sched_ctrl

Overview:
- Wishbone-mapped controller that configures, sequences and arbitrates the user-project counter datapath.
- Holds the counter plus its reload/compare configuration, and runs a periodic/one-shot state machine.
- Arbitrates counter writes among Wishbone, the logic-analyzer load port and internal reload.
- Drives the count value to IO pads, plus an interrupt and a running flag.

Parameters:
- BITS, 32, counter/register width (fixed 32 for byte strobes)
- ADDR_BASE, 32'h3000_0000, Wishbone base address; block decodes wbs_adr_i[31:8] == ADDR_BASE[31:8]

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte strobes
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- la_load_valid  in  1  LA request to load counter
- la_load_data  in  BITS  LA load value
- cnt_value  out  BITS  live counter
- cnt_running  out  1  high in RUN state
- irq  out  1  level interrupt = |(STATUS & IRQ_EN)

Behaviour:
- Register map (offset[7:0]):
  - 0x00 CTRL: bit0 EN, bit1 ONESHOT, bit2 IE_MATCH, bit3 IE_WRAP.
  - 0x04 RELOAD.
  - 0x08 COMPARE.
  - 0x0C COUNT: read live value; a write loads the counter.
  - 0x10 STATUS: bit0 MATCH, bit1 DONE, bit2 WRAP; sticky, write-1-to-clear.
  - Other offsets read 0; writes to them are ignored but still acked.
- Handshake:
  - Request = cyc & stb & addr hit & !ack.
  - ack is high exactly one cycle, the cycle after the request; no back-to-back ack.
  - wbs_dat_o is registered and valid with ack.
  - Byte strobes apply to every register.
- Reset: all registers, status, wbs_ack_o, wbs_dat_o, cnt_value, irq, cnt_running = 0; FSM = IDLE.
- FSM:
  - IDLE: counter holds. EN rising (CTRL write with EN=1) -> RUN; counter loads RELOAD on entry.
  - RUN: count += 1 per tick. If count == COMPARE: set MATCH. Then:
    - ONESHOT=0: count <= RELOAD next cycle.
    - ONESHOT=1: set DONE, clear EN, go to HALT.
  - RUN, EN written 0 -> IDLE; count holds.
  - HALT: count holds. EN written 1 -> RUN with reload.
- Wrap: increment from all-ones gives 0 and sets WRAP, unless compare matched in the same cycle (match/reload wins).
- Counter write priority, highest first: reset, WB COUNT write, la_load_valid, compare reload, increment. A loaded value takes effect the next cycle; no compare check is made on the load cycle.
- STATUS set vs W1C in the same cycle: set wins.
- RELOAD/COMPARE writes in RUN take effect on the next compare.
- Reset asserted mid-transfer: ack drops and the transaction is lost. The master must retry.

Optional Feature:
- Macro COUNTER_SCHED_PRESCALER_EN.
  - Defined: adds PRESCALE register at 0x14 (reset 0) and a prescale counter; a tick occurs every PRESCALE+1 cycles. The prescaler restarts on entry to RUN and on any counter load.
  - Undefined: tick every cycle; 0x14 reads 0 and writes are ignored.

Decomposition:
- Package counter_sched_pkg:
  - register offset localparams;
  - CTRL/STATUS bit indices;
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2).
- One sub-module, counter_sched_wb_if: Wishbone decode, ack generation, byte-strobe merge, read mux registering.
- FSM and counter remain in the top.

Test Plan:
- Periodic run:
  - Stimulus: RELOAD=0, COMPARE=4, CTRL=0x5 (EN, IE_MATCH).
  - Required: cnt_value 0,1,2,3,4,0,… ; MATCH=1, irq=1 on the cycle after count 4.
  - Then write STATUS=0x1 -> irq=0.
- One-shot:
  - Stimulus: RELOAD=10, COMPARE=12, CTRL=0x3.
  - Required: count 10,11,12 then holds at 12; STATUS=0x3; CTRL reads 0x2; cnt_running=0.
- Wrap:
  - Stimulus: COUNT write 32'hFFFF_FFFE, COMPARE=5, CTRL=0x9.
  - Required: count goes to 0; WRAP=1; irq=1.
- Arbitration:
  - Stimulus: WB COUNT write 0x100 and la_load_valid with 0x200 in the same cycle.
  - Required: count=0x100. Next cycle with LA only: 0x200.
- Byte strobes / unmapped:
  - Stimulus: write COMPARE=0xAABBCCDD with sel=4'b0101.
  - Required: COMPARE reads 0x00BB00DD.
  - Required: read of offset 0x40 returns 0 with a single ack.
- Reset mid-run:
  - Stimulus: assert reset during RUN at count 7.
  - Required: next cycle count=0, FSM IDLE, STATUS=0, ack=0.
